wb_regfile_flags: RTL and testbench
===================================

# wb_regfile_flags

Writeback stage of the dual-issue pipeline; consumes the MEM/WB register outputs directly. Holds the 8-entry × 32-bit general register file with two write ports and four read ports, plus the architectural NZCV flag register with per-flag update from both instructions. Inst2 is the younger instruction and takes priority on any conflict. Read ports feed the decode stage; an optional write-through bypass makes same-cycle writes visible to reads.

## Interface

Parameters:
- DATA_W, 32, register and write-data width
- CNT_W, 16, width of the writeback event counter

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- P4_regWrite1  input  1  inst1 register write enable
- DestReg1  input  3  inst1 destination register
- WriteData1  input  DATA_W  inst1 ALU result
- P4_regWrite2  input  1  inst2 register write enable
- DestReg2  input  3  inst2 destination register
- WriteData2  input  DATA_W  inst2 memory/zero-extended result
- inst1{N,Z,C,V}FlagVal  input  1 each  inst1 flag values
- inst1{N,Z,C,V}FlagVal_signal  input  1 each  inst1 per-flag update enables
- inst2{N,Z,C,V}FlagVal  input  1 each  inst2 flag values
- inst2{N,Z,C,V}FlagVal_signal  input  1 each  inst2 per-flag update enables
- rs1a, rs1b, rs2a, rs2b  input  3 each  read addresses (inst1 A/B, inst2 A/B of decode)
- rd1a, rd1b, rd2a, rd2b  output  DATA_W each  read data
- NFlag, ZFlag, CFlag, VFlag  output  1 each  architectural flags
- wb_count  output  CNT_W  count of register writes committed, saturating

## Operation

- Register file: 8 × DATA_W flops. On rising clk, if P4_regWrite1, reg[DestReg1] ← WriteData1; if P4_regWrite2, reg[DestReg2] ← WriteData2.
- Same-destination collision (both enables, DestReg1 == DestReg2): only WriteData2 is stored.
- Flags: each flag updated independently. For flag F: if inst2 F_signal, F ← inst2 value; else if inst1 F_signal, F ← inst1 value; else hold. Mixed enables are legal (e.g. inst1 writes C, inst2 writes N,Z → all three update).
- Read ports: combinational from the array (see Configuration for bypass). All four ports independent; any may alias any other.
- wb_count: increments by number of enabled register writes in the cycle (0, 1 or 2); a same-destination collision still counts 2. Saturates at 2^CNT_W−1; never wraps. Flag-only updates do not count.
- No register is hardwired to zero; reg 0 is writable.

## Timing

- Reset (reset = 0, asynchronous): all 8 registers = 0, N=Z=C=V=0, wb_count = 0; rd* outputs reflect zeroed array immediately. Assertion mid-operation discards any in-flight write of that edge.
- Write latency: data on inputs at edge k is in the array and on flag outputs after edge k (visible from cycle k+1 without bypass).
- Flag outputs are direct flop outputs; no combinational path from flag inputs.
- Release of reset: first write takes effect on the first rising edge with reset = 1.
- Saturation: at count 2^CNT_W−2 with two writes, result is 2^CNT_W−1.

## Configuration

- WB_BYPASS_EN defined: each read port returns same-cycle write data when its address matches an enabled write destination; inst2 match has priority over inst1 match, then array contents. Flags unaffected.
- WB_BYPASS_EN undefined: reads return array contents only; same-cycle writes appear next cycle. Decode must stall or forward externally.

## Test plan

- Reset: hold reset = 0, then release → all rd* = 0, NZCV = 0000, wb_count = 0.
- Dual write: regWrite1 DestReg1=3 WriteData1=0x11111111, regWrite2 DestReg2=5 WriteData2=0x22222222 → after edge, rs1a=3 reads 0x11111111, rs2b=5 reads 0x22222222, wb_count = 2.
- Collision: both write reg 4 with 0xAAAA0000 (inst1) and 0x0000BBBB (inst2) → reg 4 = 0x0000BBBB, wb_count +2.
- Flags mixed: inst1 signals C,V with C=1,V=1; inst2 signals N,V with N=1,V=0; prior NZCV=0100 → NZCV = 1110.
- Bypass: write reg 2 = 0xDEADBEEF, same cycle rs1a=2 → with WB_BYPASS_EN rd1a = 0xDEADBEEF before edge; without, old value until after edge.
- Saturation with CNT_W=4: drive 8 dual-write cycles → wb_count reaches 15 and holds; async reset mid-cycle with pending write → array stays 0.

Source files
------------

// File: rtl/wb_regfile_flags_if.sv
// Bus bundle for wb_regfile_flags.
// Master (MEM/WB + decode side) drives the two write ports, the per-flag values
// and enables, and the four read addresses. Slave (the register file) returns
// the four read-data words, the NZCV flags and the writeback event counter.
interface wb_regfile_flags_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  // Write ports; inst2 is the younger instruction.
  logic              P4_regWrite1;
  logic [2:0]        DestReg1;
  logic [DATA_W-1:0] WriteData1;
  logic              P4_regWrite2;
  logic [2:0]        DestReg2;
  logic [DATA_W-1:0] WriteData2;

  // Flag values and per-flag update enables.
  logic inst1NFlagVal, inst1ZFlagVal, inst1CFlagVal, inst1VFlagVal;
  logic inst1NFlagVal_signal, inst1ZFlagVal_signal, inst1CFlagVal_signal, inst1VFlagVal_signal;
  logic inst2NFlagVal, inst2ZFlagVal, inst2CFlagVal, inst2VFlagVal;
  logic inst2NFlagVal_signal, inst2ZFlagVal_signal, inst2CFlagVal_signal, inst2VFlagVal_signal;

  // Read ports.
  logic [2:0]        rs1a, rs1b, rs2a, rs2b;
  logic [DATA_W-1:0] rd1a, rd1b, rd2a, rd2b;

  // Architectural state outputs.
  logic             NFlag, ZFlag, CFlag, VFlag;
  logic [CNT_W-1:0] wb_count;

  modport master (
    output P4_regWrite1, DestReg1, WriteData1, P4_regWrite2, DestReg2, WriteData2,
    output inst1NFlagVal, inst1ZFlagVal, inst1CFlagVal, inst1VFlagVal,
    output inst1NFlagVal_signal, inst1ZFlagVal_signal, inst1CFlagVal_signal,
    output inst1VFlagVal_signal,
    output inst2NFlagVal, inst2ZFlagVal, inst2CFlagVal, inst2VFlagVal,
    output inst2NFlagVal_signal, inst2ZFlagVal_signal, inst2CFlagVal_signal,
    output inst2VFlagVal_signal,
    output rs1a, rs1b, rs2a, rs2b,
    input  rd1a, rd1b, rd2a, rd2b,
    input  NFlag, ZFlag, CFlag, VFlag, wb_count
  );

  modport slave (
    input  P4_regWrite1, DestReg1, WriteData1, P4_regWrite2, DestReg2, WriteData2,
    input  inst1NFlagVal, inst1ZFlagVal, inst1CFlagVal, inst1VFlagVal,
    input  inst1NFlagVal_signal, inst1ZFlagVal_signal, inst1CFlagVal_signal,
    input  inst1VFlagVal_signal,
    input  inst2NFlagVal, inst2ZFlagVal, inst2CFlagVal, inst2VFlagVal,
    input  inst2NFlagVal_signal, inst2ZFlagVal_signal, inst2CFlagVal_signal,
    input  inst2VFlagVal_signal,
    input  rs1a, rs1b, rs2a, rs2b,
    output rd1a, rd1b, rd2a, rd2b,
    output NFlag, ZFlag, CFlag, VFlag, wb_count
  );
endinterface

// File: rtl/wb_regfile_flags.sv
// Writeback stage of the dual-issue pipeline: 8 x DATA_W register file with two
// write ports and four read ports, NZCV flag register and a saturating count of
// committed register writes. Inst2 (younger) wins every conflict.
//
// Ports:
//   clk   - pipeline clock, all state on rising edge
//   reset - asynchronous, active-low; clears registers, flags and counter
//   bus   - wb_regfile_flags_if.slave: write ports, flag values/enables,
//           read addresses in; read data, NZCV and wb_count out
//
// Build option: define WB_BYPASS_EN to make same-cycle writes visible on the
// read ports (inst2 match over inst1 match over array). Flags are never bypassed.
module wb_regfile_flags #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  wb_regfile_flags_if.slave bus
);

  localparam logic [CNT_W:0] CntMax = {1'b0, {CNT_W{1'b1}}};

  logic [DATA_W-1:0] regsQ [8];
  logic [3:0]        flagsQ, flagsD;
  logic [3:0]        val1, sig1, val2, sig2;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [CNT_W:0]    cntSum;
  logic [1:0]        nWrites;

  logic              we1, we2;
  logic [2:0]        dest1, dest2;
  logic [DATA_W-1:0] wdata1, wdata2;

  logic [2:0]        rAddr [4];
  logic [DATA_W-1:0] rData [4];

  assign we1    = bus.P4_regWrite1;
  assign we2    = bus.P4_regWrite2;
  assign dest1  = bus.DestReg1;
  assign dest2  = bus.DestReg2;
  assign wdata1 = bus.WriteData1;
  assign wdata2 = bus.WriteData2;

  // Flag vectors ordered {N, Z, C, V}.
  assign val1 = {bus.inst1NFlagVal, bus.inst1ZFlagVal, bus.inst1CFlagVal, bus.inst1VFlagVal};
  assign sig1 = {bus.inst1NFlagVal_signal, bus.inst1ZFlagVal_signal,
                 bus.inst1CFlagVal_signal, bus.inst1VFlagVal_signal};
  assign val2 = {bus.inst2NFlagVal, bus.inst2ZFlagVal, bus.inst2CFlagVal, bus.inst2VFlagVal};
  assign sig2 = {bus.inst2NFlagVal_signal, bus.inst2ZFlagVal_signal,
                 bus.inst2CFlagVal_signal, bus.inst2VFlagVal_signal};

  always_comb begin
    flagsD = flagsQ;
    for (int f = 0; f < 4; f++) begin
      if (sig2[f]) begin
        flagsD[f] = val2[f];
      end else if (sig1[f]) begin
        flagsD[f] = val1[f];
      end
    end
  end

  // A same-destination collision still counts as two committed writes.
  always_comb begin
    nWrites = {1'b0, we1} + {1'b0, we2};
    cntSum  = {1'b0, cntQ} + {{(CNT_W - 1){1'b0}}, nWrites};
    cntD    = (cntSum > CntMax) ? CntMax[CNT_W-1:0] : cntSum[CNT_W-1:0];
  end

  // Port 2 is written last so it overrides port 1 on a shared destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regsQ[i] <= '0;
      end
    end else begin
      if (we1) begin
        regsQ[dest1] <= wdata1;
      end
      if (we2) begin
        regsQ[dest2] <= wdata2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flagsQ <= '0;
      cntQ   <= '0;
    end else begin
      flagsQ <= flagsD;
      cntQ   <= cntD;
    end
  end

  assign rAddr[0] = bus.rs1a;
  assign rAddr[1] = bus.rs1b;
  assign rAddr[2] = bus.rs2a;
  assign rAddr[3] = bus.rs2b;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rData[p] = regsQ[rAddr[p]];
`ifdef WB_BYPASS_EN
      if (we2 && (dest2 == rAddr[p])) begin
        rData[p] = wdata2;
      end else if (we1 && (dest1 == rAddr[p])) begin
        rData[p] = wdata1;
      end
`endif
    end
  end

  assign bus.rd1a = rData[0];
  assign bus.rd1b = rData[1];
  assign bus.rd2a = rData[2];
  assign bus.rd2b = rData[3];

  assign bus.NFlag    = flagsQ[3];
  assign bus.ZFlag    = flagsQ[2];
  assign bus.CFlag    = flagsQ[1];
  assign bus.VFlag    = flagsQ[0];
  assign bus.wb_count = cntQ;

endmodule

// File: tb/tb_wb_regfile_flags.sv
// Directed bench for wb_regfile_flags: one full-width instance (CNT_W=16) for
// the functional scenarios and one CNT_W=4 instance for counter saturation and
// mid-cycle asynchronous reset. Inputs change on the falling edge; outputs are
// checked on the following falling edge (or #1 after a change for comb paths).
module tb_wb_regfile_flags;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  wb_regfile_flags_if #(.DATA_W(32), .CNT_W(16)) busM ();
  wb_regfile_flags_if #(.DATA_W(32), .CNT_W(4))  busS ();

  wb_regfile_flags #(.DATA_W(32), .CNT_W(16)) dutMain (
    .clk   (clk),
    .reset (reset),
    .bus   (busM)
  );

  wb_regfile_flags #(.DATA_W(32), .CNT_W(4)) dutSmall (
    .clk   (clk),
    .reset (reset),
    .bus   (busS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_main();
    busM.P4_regWrite1 = 0; busM.DestReg1 = 0; busM.WriteData1 = 0;
    busM.P4_regWrite2 = 0; busM.DestReg2 = 0; busM.WriteData2 = 0;
    {busM.inst1NFlagVal, busM.inst1ZFlagVal, busM.inst1CFlagVal, busM.inst1VFlagVal} = 4'b0;
    {busM.inst1NFlagVal_signal, busM.inst1ZFlagVal_signal, busM.inst1CFlagVal_signal,
     busM.inst1VFlagVal_signal} = 4'b0;
    {busM.inst2NFlagVal, busM.inst2ZFlagVal, busM.inst2CFlagVal, busM.inst2VFlagVal} = 4'b0;
    {busM.inst2NFlagVal_signal, busM.inst2ZFlagVal_signal, busM.inst2CFlagVal_signal,
     busM.inst2VFlagVal_signal} = 4'b0;
  endtask

  task automatic idle_small();
    busS.P4_regWrite1 = 0; busS.DestReg1 = 0; busS.WriteData1 = 0;
    busS.P4_regWrite2 = 0; busS.DestReg2 = 0; busS.WriteData2 = 0;
    {busS.inst1NFlagVal, busS.inst1ZFlagVal, busS.inst1CFlagVal, busS.inst1VFlagVal} = 4'b0;
    {busS.inst1NFlagVal_signal, busS.inst1ZFlagVal_signal, busS.inst1CFlagVal_signal,
     busS.inst1VFlagVal_signal} = 4'b0;
    {busS.inst2NFlagVal, busS.inst2ZFlagVal, busS.inst2CFlagVal, busS.inst2VFlagVal} = 4'b0;
    {busS.inst2NFlagVal_signal, busS.inst2ZFlagVal_signal, busS.inst2CFlagVal_signal,
     busS.inst2VFlagVal_signal} = 4'b0;
    busS.rs1a = 0; busS.rs1b = 0; busS.rs2a = 0; busS.rs2b = 0;
  endtask

  task automatic test_reset();
    logic [3:0] nzcv;
    reset = 1'b0;
    idle_main();
    idle_small();
    busM.rs1a = 3; busM.rs1b = 5; busM.rs2a = 0; busM.rs2b = 7;
    // Writes pending while reset is held must be ignored.
    busM.P4_regWrite1 = 1; busM.DestReg1 = 3; busM.WriteData1 = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    idle_main();
    reset = 1'b1;
    @(negedge clk);
    nzcv = {busM.NFlag, busM.ZFlag, busM.CFlag, busM.VFlag};
    checks++;
    if (busM.rd1a !== 32'h0) begin
      errors++; $display("FAIL reset_rd1a: got %h, required 00000000", busM.rd1a);
    end
    checks++;
    if ({busM.rd1b, busM.rd2a, busM.rd2b} !== 96'h0) begin
      errors++;
      $display("FAIL reset_rd_other: got %h %h %h, required 0", busM.rd1b, busM.rd2a, busM.rd2b);
    end
    checks++;
    if (nzcv !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, required 0000", nzcv);
    end
    checks++;
    if (busM.wb_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d, required 0", busM.wb_count);
    end
  endtask

  task automatic test_dual_write();
    busM.P4_regWrite1 = 1; busM.DestReg1 = 3; busM.WriteData1 = 32'h1111_1111;
    busM.P4_regWrite2 = 1; busM.DestReg2 = 5; busM.WriteData2 = 32'h2222_2222;
    busM.rs1a = 3; busM.rs1b = 0; busM.rs2a = 3; busM.rs2b = 5;
    @(negedge clk);
    idle_main();
    @(negedge clk);
    checks++;
    if (busM.rd1a !== 32'h1111_1111) begin
      errors++; $display("FAIL dual_rd1a: got %h, required 11111111", busM.rd1a);
    end
    checks++;
    if (busM.rd2b !== 32'h2222_2222) begin
      errors++; $display("FAIL dual_rd2b: got %h, required 22222222", busM.rd2b);
    end
    checks++;
    if (busM.rd2a !== 32'h1111_1111) begin
      errors++; $display("FAIL dual_alias_rd2a: got %h, required 11111111", busM.rd2a);
    end
    checks++;
    if (busM.rd1b !== 32'h0) begin
      errors++; $display("FAIL dual_untouched_rd1b: got %h, required 00000000", busM.rd1b);
    end
    checks++;
    if (busM.wb_count !== 16'd2) begin
      errors++; $display("FAIL dual_count: got %0d, required 2", busM.wb_count);
    end
  endtask

  task automatic test_collision();
    busM.P4_regWrite1 = 1; busM.DestReg1 = 4; busM.WriteData1 = 32'hAAAA_0000;
    busM.P4_regWrite2 = 1; busM.DestReg2 = 4; busM.WriteData2 = 32'h0000_BBBB;
    busM.rs1b = 4;
    @(negedge clk);
    idle_main();
    @(negedge clk);
    checks++;
    if (busM.rd1b !== 32'h0000_BBBB) begin
      errors++; $display("FAIL collision_data: got %h, required 0000bbbb", busM.rd1b);
    end
    checks++;
    if (busM.wb_count !== 16'd4) begin
      errors++; $display("FAIL collision_count: got %0d, required 4", busM.wb_count);
    end
  endtask

  task automatic test_reg0();
    busM.P4_regWrite1 = 1; busM.DestReg1 = 0; busM.WriteData1 = 32'h1234_5678;
    busM.rs2a = 0;
    @(negedge clk);
    idle_main();
    @(negedge clk);
    checks++;
    if (busM.rd2a !== 32'h1234_5678) begin
      errors++; $display("FAIL reg0_writable: got %h, required 12345678", busM.rd2a);
    end
    checks++;
    if (busM.wb_count !== 16'd5) begin
      errors++; $display("FAIL reg0_count: got %0d, required 5", busM.wb_count);
    end
  endtask

  task automatic test_flags();
    logic [3:0] nzcv;
    // Establish NZCV = 0100.
    busM.inst1ZFlagVal = 1; busM.inst1ZFlagVal_signal = 1;
    @(negedge clk);
    idle_main();
    nzcv = {busM.NFlag, busM.ZFlag, busM.CFlag, busM.VFlag};
    checks++;
    if (nzcv !== 4'b0100) begin
      errors++; $display("FAIL flags_setup: got %b, required 0100", nzcv);
    end
    // Mixed update; unenabled values are set to opposite levels as decoys.
    busM.inst1CFlagVal = 1; busM.inst1CFlagVal_signal = 1;
    busM.inst1VFlagVal = 1; busM.inst1VFlagVal_signal = 1;
    busM.inst1ZFlagVal = 0;
    busM.inst2NFlagVal = 1; busM.inst2NFlagVal_signal = 1;
    busM.inst2VFlagVal = 0; busM.inst2VFlagVal_signal = 1;
    busM.inst2CFlagVal = 0; busM.inst2ZFlagVal = 0;
    #1;
    nzcv = {busM.NFlag, busM.ZFlag, busM.CFlag, busM.VFlag};
    checks++;
    if (nzcv !== 4'b0100) begin
      errors++; $display("FAIL flags_no_comb_path: got %b, required 0100", nzcv);
    end
    @(negedge clk);
    idle_main();
    busM.inst1NFlagVal = 0; busM.inst2ZFlagVal = 1; busM.inst2CFlagVal = 0;
    nzcv = {busM.NFlag, busM.ZFlag, busM.CFlag, busM.VFlag};
    checks++;
    if (nzcv !== 4'b1110) begin
      errors++; $display("FAIL flags_mixed: got %b, required 1110", nzcv);
    end
    @(negedge clk);
    idle_main();
    nzcv = {busM.NFlag, busM.ZFlag, busM.CFlag, busM.VFlag};
    checks++;
    if (nzcv !== 4'b1110) begin
      errors++; $display("FAIL flags_hold: got %b, required 1110", nzcv);
    end
    checks++;
    if (busM.wb_count !== 16'd5) begin
      errors++; $display("FAIL flags_no_count: got %0d, required 5", busM.wb_count);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    busM.P4_regWrite1 = 1; busM.DestReg1 = 2; busM.WriteData1 = 32'hDEAD_BEEF;
    busM.rs1a = 2;
    #1;
`ifdef WB_BYPASS_EN
    exp = 32'hDEAD_BEEF;
`else
    exp = 32'h0;
`endif
    checks++;
    if (busM.rd1a !== exp) begin
      errors++; $display("FAIL bypass_same_cycle: got %h, required %h", busM.rd1a, exp);
    end
    @(negedge clk);
    idle_main();
    checks++;
    if (busM.rd1a !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_after_edge: got %h, required deadbeef", busM.rd1a);
    end
    // Both write reg 6: bypass must pick inst2.
    busM.P4_regWrite1 = 1; busM.DestReg1 = 6; busM.WriteData1 = 32'hCAFE_0001;
    busM.P4_regWrite2 = 1; busM.DestReg2 = 6; busM.WriteData2 = 32'hCAFE_0002;
    busM.rs2a = 6;
    #1;
`ifdef WB_BYPASS_EN
    exp = 32'hCAFE_0002;
`else
    exp = 32'h0;
`endif
    checks++;
    if (busM.rd2a !== exp) begin
      errors++; $display("FAIL bypass_priority: got %h, required %h", busM.rd2a, exp);
    end
    @(negedge clk);
    idle_main();
    checks++;
    if (busM.rd2a !== 32'hCAFE_0002) begin
      errors++; $display("FAIL bypass_priority_after: got %h, required cafe0002", busM.rd2a);
    end
    checks++;
    if (busM.wb_count !== 16'd8) begin
      errors++; $display("FAIL bypass_count: got %0d, required 8", busM.wb_count);
    end
  endtask

  task automatic test_saturation();
    busS.P4_regWrite1 = 1; busS.DestReg1 = 1; busS.WriteData1 = 32'h0000_00A1;
    busS.P4_regWrite2 = 1; busS.DestReg2 = 2; busS.WriteData2 = 32'h0000_00B2;
    busS.rs1a = 1;
    repeat (7) @(negedge clk);
    checks++;
    if (busS.wb_count !== 4'd14) begin
      errors++; $display("FAIL sat_before: got %0d, required 14", busS.wb_count);
    end
    @(negedge clk);
    checks++;
    if (busS.wb_count !== 4'd15) begin
      errors++; $display("FAIL sat_reach: got %0d, required 15", busS.wb_count);
    end
    @(negedge clk);
    idle_small();
    checks++;
    if (busS.wb_count !== 4'd15) begin
      errors++; $display("FAIL sat_hold: got %0d, required 15", busS.wb_count);
    end
  endtask

  task automatic test_async_reset();
    busS.rs1a = 1;
    #1;
    checks++;
    if (busS.rd1a !== 32'h0000_00A1) begin
      errors++; $display("FAIL areset_pre: got %h, required 000000a1", busS.rd1a);
    end
    busS.P4_regWrite1 = 1; busS.DestReg1 = 1; busS.WriteData1 = 32'h0000_1234;
    busM.P4_regWrite1 = 1; busM.DestReg1 = 7; busM.WriteData1 = 32'h0000_0055;
    busM.rs1a = 7;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busS.rd1a !== 32'h0 || busS.wb_count !== 4'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h/%0d, required 0/0", busS.rd1a, busS.wb_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busS.rd1a !== 32'h0 || busM.rd1a !== 32'h0) begin
      errors++;
      $display("FAIL areset_discard: got %h/%h, required 0/0", busS.rd1a, busM.rd1a);
    end
    checks++;
    if (busM.wb_count !== 16'd0 || busM.NFlag !== 1'b0) begin
      errors++;
      $display("FAIL areset_main_state: got %0d/%b, required 0/0", busM.wb_count, busM.NFlag);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle_small();
    idle_main();
    busS.rs1a = 1;
    #1;
    checks++;
    if (busS.rd1a !== 32'h0000_1234 || busS.wb_count !== 4'd1) begin
      errors++;
      $display("FAIL areset_release: got %h/%0d, required 00001234/1", busS.rd1a,
               busS.wb_count);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_dual_write();
    test_collision();
    test_reg0();
    test_flags();
    test_bypass();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
